// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decode-state and command enums for the PS/2 board controller.
// Scan-code set 2 make codes; E0 marks the extended (arrow) keys, F0 marks a break.
package ps2_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_UP,
        CMD_DOWN,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_ENTER,
        CMD_ESC
    } cmd_t;

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == SC_E0) || (code == SC_F0);
    endfunction

    // Arrow keys only count with the E0 prefix, WASD-style keys and Esc only without it.
    function automatic cmd_t key_map(input logic [7:0] code, input logic ext);
        cmd_t c;
        c = CMD_NONE;
        if (ext) begin
            case (code)
                SC_UP:    c = CMD_UP;
                SC_DOWN:  c = CMD_DOWN;
                SC_LEFT:  c = CMD_LEFT;
                SC_RIGHT: c = CMD_RIGHT;
                SC_ENTER: c = CMD_ENTER;
                default:  c = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_W:     c = CMD_UP;
                SC_S:     c = CMD_DOWN;
                SC_A:     c = CMD_LEFT;
                SC_D:     c = CMD_RIGHT;
                SC_ENTER: c = CMD_ENTER;
                SC_ESC:   c = CMD_ESC;
                default:  c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

    function automatic logic [5:0] cmd_mask(input cmd_t c);
        logic [5:0] m;
        m = 6'b000000;
        case (c)
            CMD_UP:    m = 6'b000001;
            CMD_DOWN:  m = 6'b000010;
            CMD_LEFT:  m = 6'b000100;
            CMD_RIGHT: m = 6'b001000;
            CMD_ENTER: m = 6'b010000;
            CMD_ESC:   m = 6'b100000;
            default:   m = 6'b000000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_code_decode.sv
// Scan-code decoder: prefix FSM with timeout, key map and typematic-repeat suppression.
// Emits a combinational one-cycle command strobe for the byte currently on the bus.
module ps2_code_decode
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte_data,
    output logic       o_cmd_stb,
    output cmd_t       o_cmd,
    output logic       o_err_pulse
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    dec_state_t    r_state;
    dec_state_t    w_state_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic [5:0]    r_held;
    logic          r_err;

    logic          w_timeout;
    logic          w_make;
    logic          w_brk;
    logic          w_ext;
    logic          w_err;
    cmd_t          w_key;
    logic [5:0]    w_key_mask;
    logic          w_known;

    assign w_timeout = !i_byte_valid && (r_state != ST_IDLE)
                       && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_byte_data == SC_E0)      w_state_nxt = ST_EXT;
                    else if (i_byte_data == SC_F0) w_state_nxt = ST_BRK;
                end
                ST_EXT: begin
                    if (i_byte_data == SC_F0)      w_state_nxt = ST_EXT_BRK;
                    else if (i_byte_data != SC_E0) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_make = 1'b0;
        w_brk  = 1'b0;
        w_ext  = 1'b0;
        w_err  = 1'b0;
        if (i_byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_make = !is_prefix(i_byte_data);
                end
                ST_EXT: begin
                    w_ext  = 1'b1;
                    w_err  = (i_byte_data == SC_E0);
                    w_make = !is_prefix(i_byte_data);
                end
                ST_BRK: begin
                    w_err = is_prefix(i_byte_data);
                    w_brk = !is_prefix(i_byte_data);
                end
                default: begin
                    w_ext = 1'b1;
                    w_err = is_prefix(i_byte_data);
                    w_brk = !is_prefix(i_byte_data);
                end
            endcase
        end else if (w_timeout) begin
            w_err = 1'b1;
        end
    end

    assign w_key      = key_map(i_byte_data, w_ext);
    assign w_key_mask = cmd_mask(w_key);
    assign w_known    = (w_key != CMD_NONE);

    // A make for a key already held is a typematic repeat and issues nothing.
    assign o_cmd_stb   = w_make && w_known && ((r_held & w_key_mask) == 6'b000000);
    assign o_cmd       = o_cmd_stb ? w_key : CMD_NONE;
    assign o_err_pulse = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (i_byte_valid || (r_state == ST_IDLE) || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= 6'b000000;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_make && w_known) begin
                r_held <= r_held | w_key_mask;
            end else if (w_brk && w_known) begin
                r_held <= r_held & ~w_key_mask;
            end
        end
    end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Keyboard-to-board controller: cursor, piece selection and move handoff to the rules engine.
// Key decoding lives in ps2_code_decode; this level only reacts to its command strobe.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int BOARD_N     = 11,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CW          = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic [CW-1:0]   cur_row,
    output logic [CW-1:0]   cur_col,
    output logic            sel_valid,
    output logic [CW-1:0]   sel_row,
    output logic [CW-1:0]   sel_col,
    output logic            move_valid,
    output logic [2*CW-1:0] move_from,
    output logic [2*CW-1:0] move_to,
    input  logic            move_ready,
    output logic            cancel_pulse,
    output logic            err_pulse
);

    localparam logic [CW-1:0] C_MAX = CW'(BOARD_N - 1);
    localparam logic [CW-1:0] C_MID = CW'((BOARD_N - 1) / 2);

    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic            r_sel_valid;
    logic [CW-1:0]   r_sel_row;
    logic [CW-1:0]   r_sel_col;
    logic            r_move_valid;
    logic [2*CW-1:0] r_move_from;
    logic [2*CW-1:0] r_move_to;
    logic            r_cancel;

    logic            w_cmd_stb;
    cmd_t            w_cmd;
    logic            w_err;
    logic            w_on_sel;

    ps2_code_decode #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_decode (
        .clk          (clk),
        .rst          (rst),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_cmd_stb    (w_cmd_stb),
        .o_cmd        (w_cmd),
        .o_err_pulse  (w_err)
    );

    assign w_on_sel = (r_row == r_sel_row) && (r_col == r_sel_col);

    // A pending move freezes the board; only the handshake can release it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= C_MID;
            r_col        <= C_MID;
            r_sel_valid  <= 1'b0;
            r_sel_row    <= '0;
            r_sel_col    <= '0;
            r_move_valid <= 1'b0;
            r_move_from  <= '0;
            r_move_to    <= '0;
            r_cancel     <= 1'b0;
        end else begin
            r_cancel <= 1'b0;
            if (r_move_valid) begin
                if (move_ready) begin
                    r_move_valid <= 1'b0;
                    r_sel_valid  <= 1'b0;
                end
            end else if (w_cmd_stb) begin
                case (w_cmd)
                    CMD_UP: begin
                        if (r_row != '0) r_row <= r_row - CW'(1);
                    end
                    CMD_DOWN: begin
                        if (r_row != C_MAX) r_row <= r_row + CW'(1);
                    end
                    CMD_LEFT: begin
                        if (r_col != '0) r_col <= r_col - CW'(1);
                    end
                    CMD_RIGHT: begin
                        if (r_col != C_MAX) r_col <= r_col + CW'(1);
                    end
                    CMD_ENTER: begin
                        if (!r_sel_valid) begin
                            r_sel_valid <= 1'b1;
                            r_sel_row   <= r_row;
                            r_sel_col   <= r_col;
                        end else if (w_on_sel) begin
                            r_sel_valid <= 1'b0;
                        end else begin
                            r_move_from  <= {r_sel_row, r_sel_col};
                            r_move_to    <= {r_row, r_col};
                            r_move_valid <= 1'b1;
                        end
                    end
                    CMD_ESC: begin
                        if (r_sel_valid) begin
                            r_sel_valid <= 1'b0;
                            r_cancel    <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cur_row      = r_row;
    assign cur_col      = r_col;
    assign sel_valid    = r_sel_valid;
    assign sel_row      = r_sel_row;
    assign sel_col      = r_sel_col;
    assign move_valid   = r_move_valid;
    assign move_from    = r_move_from;
    assign move_to      = r_move_to;
    assign cancel_pulse = r_cancel;
    assign err_pulse    = w_err;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl: a behavioural model pushes the expected
// outputs for every driven cycle and they are compared one cycle later.
module tb_ps2_cmd_ctrl;

    localparam int BOARD_N = 11;
    localparam int TMO     = 40;
    localparam int CW      = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            byte_valid = 1'b0;
    logic [7:0]      byte_data = 8'h00;
    logic            move_ready = 1'b0;
    logic [CW-1:0]   cur_row, cur_col, sel_row, sel_col;
    logic            sel_valid, move_valid, cancel_pulse, err_pulse;
    logic [2*CW-1:0] move_from, move_to;

    always #5 clk = ~clk;

    ps2_cmd_ctrl #(
        .BOARD_N     (BOARD_N),
        .TIMEOUT_CYC (TMO),
        .CW          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .cur_row      (cur_row),
        .cur_col      (cur_col),
        .sel_valid    (sel_valid),
        .sel_row      (sel_row),
        .sel_col      (sel_col),
        .move_valid   (move_valid),
        .move_from    (move_from),
        .move_to      (move_to),
        .move_ready   (move_ready),
        .cancel_pulse (cancel_pulse),
        .err_pulse    (err_pulse)
    );

    typedef struct {
        logic [CW-1:0]   row, col, sr, sc;
        logic            sv, mv, cancel, err;
        logic [2*CW-1:0] mf, mt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   g_rdy  = 1'b0;
    int   err_seen = 0;
    int   cancel_seen = 0;

    // Behavioural model state
    int       m_st, m_tmo, m_row, m_col, m_sr, m_sc;
    bit [5:0] m_held;
    bit       m_sv, m_mv, m_cancel, m_err;
    logic [2*CW-1:0] m_mf, m_mt;

    always @(negedge clk) begin
        if (err_pulse === 1'b1)    err_seen++;
        if (cancel_pulse === 1'b1) cancel_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int key_of(input logic [7:0] b, input bit ext);
        if (ext) begin
            case (b)
                8'h75: return 1;
                8'h72: return 2;
                8'h6B: return 3;
                8'h74: return 4;
                8'h5A: return 5;
                default: return 0;
            endcase
        end
        case (b)
            8'h1D: return 1;
            8'h1B: return 2;
            8'h1C: return 3;
            8'h23: return 4;
            8'h5A: return 5;
            8'h76: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        e.row = CW'(m_row); e.col = CW'(m_col);
        e.sr = CW'(m_sr);   e.sc = CW'(m_sc);
        e.sv = m_sv; e.mv = m_mv; e.cancel = m_cancel; e.err = m_err;
        e.mf = m_mf; e.mt = m_mt;
        q.push_back(e);
    endtask

    task automatic model(input bit v, input logic [7:0] b, input bit rdy, input bit r);
        int cmd = 0;
        int k;
        bit mk = 0, bk = 0, ext = 0, err = 0;
        if (r) begin
            m_st = 0; m_tmo = 0; m_held = '0;
            m_row = (BOARD_N - 1) / 2; m_col = (BOARD_N - 1) / 2;
            m_sv = 0; m_sr = 0; m_sc = 0; m_mv = 0; m_mf = '0; m_mt = '0;
            m_cancel = 0; m_err = 0;
            push_exp();
            return;
        end
        if (v) begin
            m_tmo = 0;
            case (m_st)
                0: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 2; else mk = 1;
                1: if (b == 8'hF0) m_st = 3; else if (b == 8'hE0) err = 1;
                   else begin mk = 1; ext = 1; m_st = 0; end
                default: begin
                    ext = (m_st == 3);
                    if (b == 8'hE0 || b == 8'hF0) err = 1; else bk = 1;
                    m_st = 0;
                end
            endcase
        end else if (m_st != 0) begin
            if (m_tmo == TMO - 1) begin m_st = 0; m_tmo = 0; err = 1; end
            else m_tmo++;
        end
        k = key_of(b, ext);
        if (mk && k != 0 && !m_held[k-1]) begin m_held[k-1] = 1; cmd = k; end
        if (bk && k != 0) m_held[k-1] = 0;
        m_cancel = 0;
        if (m_mv) begin
            if (rdy) begin m_mv = 0; m_sv = 0; end
        end else begin
            case (cmd)
                1: if (m_row > 0) m_row--;
                2: if (m_row < BOARD_N - 1) m_row++;
                3: if (m_col > 0) m_col--;
                4: if (m_col < BOARD_N - 1) m_col++;
                5: begin
                    if (!m_sv) begin m_sv = 1; m_sr = m_row; m_sc = m_col; end
                    else if (m_row == m_sr && m_col == m_sc) m_sv = 0;
                    else begin
                        m_mf = {CW'(m_sr), CW'(m_sc)};
                        m_mt = {CW'(m_row), CW'(m_col)};
                        m_mv = 1;
                    end
                end
                6: if (m_sv) begin m_sv = 0; m_cancel = 1; end
                default: ;
            endcase
        end
        m_err = err;
        push_exp();
    endtask

    task automatic compare_one();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        check_val("cur_row", cur_row, e.row);
        check_val("cur_col", cur_col, e.col);
        check_val("sel_valid", sel_valid, e.sv);
        check_val("sel_row", sel_row, e.sr);
        check_val("sel_col", sel_col, e.sc);
        check_val("move_valid", move_valid, e.mv);
        check_val("move_from", move_from, e.mf);
        check_val("move_to", move_to, e.mt);
        check_val("cancel_pulse", cancel_pulse, e.cancel);
        check_val("err_pulse", err_pulse, e.err);
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit r);
        @(negedge clk);
        compare_one();
        rst = r; byte_valid = v; byte_data = b; move_ready = g_rdy;
        model(v, b, g_rdy, r);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic tap_n(input logic [7:0] b);
        send(b); send(8'hF0); send(b);
    endtask

    task automatic tap_e(input logic [7:0] b);
        send(8'hE0); send(b); send(8'hE0); send(8'hF0); send(b);
    endtask

    initial begin
        int e0;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_val("rst_row", cur_row, 5);
        check_val("rst_col", cur_col, 5);
        check_val("rst_mv", move_valid, 0);

        // Extended RIGHT, then its break
        send(8'hE0); send(8'h74);
        check_val("right_col", cur_col, 6);
        send(8'hE0); send(8'hF0); send(8'h74);
        check_val("brk_col", cur_col, 6);

        // Typematic repeat, then saturation at row 0
        for (int i = 0; i < 12; i++) send(8'h1D);
        check_val("repeat_row", cur_row, 4);
        send(8'hF0); send(8'h1D);
        for (int i = 0; i < 11; i++) tap_n(8'h1D);
        check_val("sat_row", cur_row, 0);

        // Walk to (3,3) and build a move to (3,5)
        for (int i = 0; i < 3; i++) tap_n(8'h1B);
        for (int i = 0; i < 3; i++) tap_n(8'h1C);
        tap_n(8'h5A);
        tap_n(8'h23); tap_n(8'h23);
        tap_n(8'h5A);
        idle(20);
        check_val("mv_hold", move_valid, 1);
        check_val("mv_from", move_from, 8'h33);
        check_val("mv_to", move_to, 8'h35);
        tap_n(8'h1C);
        idle(2);
        check_val("drop_col", cur_col, 5);
        g_rdy = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        g_rdy = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        check_val("hs_mv", move_valid, 0);
        check_val("hs_sv", sel_valid, 0);

        // Select/cancel and select/deselect
        e0 = cancel_seen;
        tap_n(8'h5A); tap_n(8'h76);
        idle(2);
        check_val("cancel_cnt", cancel_seen - e0, 1);
        tap_n(8'h5A); tap_n(8'h5A);
        check_val("desel_sv", sel_valid, 0);
        check_val("desel_mv", move_valid, 0);
        tap_e(8'h5A); tap_n(8'h76);

        // Malformed sequences: F0 E0, and E0 E0 before an extended UP
        send(8'hF0); send(8'hE0);
        send(8'hE0); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_val("ee_row", cur_row, 2);

        // Prefix timeout, then a bare 75 is unknown
        e0 = err_seen;
        send(8'hE0);
        idle(TMO + 5);
        check_val("tmo_err_cnt", err_seen - e0, 1);
        tap_n(8'h75);
        check_val("tmo_row", cur_row, 2);

        // Reset while a move is pending
        tap_n(8'h5A); tap_e(8'h74); tap_n(8'h5A);
        check_val("pre_rst_mv", move_valid, 1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check_val("post_rst_mv", move_valid, 0);
        check_val("post_rst_row", cur_row, 5);
        check_val("post_rst_col", cur_col, 5);
        idle(2);
        @(negedge clk);
        compare_one();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
- Controller between the PS/2 byte deserializer and the Hnefatafl game logic.
- Consumes a stream of scan-code set 2 bytes and decodes the make, break and extended (E0) prefixes.
- Suppresses typematic repeats and turns keystrokes into cursor motion, piece selection and move requests on the board.
- Drives the on-screen cursor and selection highlight, and hands completed moves to the rules engine over a valid/ready handshake.

Parameters:
BOARD_N, 11, board side length; cursor row/col range 0..BOARD_N-1
TIMEOUT_CYC, 50000, clk cycles a prefix (E0/F0) may wait for its next byte before decode aborts
CW, 4, coordinate width in bits; must satisfy 2**CW >= BOARD_N

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
byte_valid  in  1  one-cycle strobe: byte_data holds a complete received byte
byte_data  in  8  received scan-code byte
cur_row  out  CW  cursor row
cur_col  out  CW  cursor column
sel_valid  out  1  a piece is selected
sel_row  out  CW  selected row (meaningful only when sel_valid=1)
sel_col  out  CW  selected column (meaningful only when sel_valid=1)
move_valid  out  1  move request pending
move_from  out  2*CW  {row,col} of source square
move_to  out  2*CW  {row,col} of destination square
move_ready  in  1  rules engine accepts the move
cancel_pulse  out  1  one-cycle pulse: selection cancelled by Esc
err_pulse  out  1  one-cycle pulse: prefix timeout or malformed sequence

Behaviour:
Interface:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: cur_row=cur_col=(BOARD_N-1)/2 (5,5). sel_valid=0, sel_row=sel_col=0, move_valid=0, move_from=move_to=0, cancel_pulse=0, err_pulse=0. Decode state=IDLE, all held flags=0, timeout counter=0.
- Reset asserted mid-operation discards any pending move; move_valid drops in the cycle after rst is sampled.

Decode FSM (advances only on byte_valid):
- IDLE: E0 -> EXT; F0 -> BRK; other byte -> make(byte, ext=0).
- EXT: F0 -> EXT_BRK; E0 -> stay in EXT, pulse err; other byte -> make(byte, ext=1), go to IDLE.
- BRK: any byte except E0/F0 -> break(byte, ext=0), go to IDLE; E0/F0 -> err, go to IDLE.
- EXT_BRK: any byte except E0/F0 -> break(byte, ext=1), go to IDLE; E0/F0 -> err, go to IDLE.
- Timeout: counter clears on every byte_valid and counts while in EXT, BRK or EXT_BRK. On reaching TIMEOUT_CYC: go to IDLE, pulse err, no command.

Key map (make/break codes):
- UP: E0 75 or 1D.
- DOWN: E0 72 or 1B.
- LEFT: E0 6B or 1C.
- RIGHT: E0 74 or 23.
- ENTER: 5A or E0 5A.
- ESC: 76.
- Any other code, including E1/pause, is ignored silently.

Held-key handling:
- One held flag per command (6 flags).
- make with flag=0: set flag, issue command.
- make with flag=1: ignored (typematic repeat).
- break: clears flag, issues nothing.
- Held flags update even while a move is pending.

Commands:
- All command effects become visible the cycle after the byte_valid that completes the code (latency 1).
- UP/DOWN/LEFT/RIGHT: row-1, row+1, col-1, col+1. Saturate at 0 and BOARD_N-1; no wrap.
- ENTER, sel_valid=0: capture the cursor into sel, set sel_valid=1.
- ENTER, sel_valid=1 and cursor==sel: clear sel_valid (deselect).
- ENTER, sel_valid=1 and cursor!=sel: set move_from=sel, move_to=cursor, move_valid=1.
- ESC, sel_valid=1: clear sel_valid, pulse cancel_pulse.
- ESC, sel_valid=0: no effect.

Move handshake:
- move_valid, move_from and move_to stay stable until a cycle with move_valid & move_ready.
- The cycle after the handshake: move_valid=0 and sel_valid=0.
- While move_valid=1, all commands (including ESC) are dropped; only the decode FSM and held flags advance.
- Commands are judged against the registered move_valid. A byte arriving in the same cycle as the handshake is therefore dropped.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants (SC_E0, SC_F0, SC_UP, SC_W, ...);
  - the decode-state enum;
  - the command enum (CMD_NONE, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_ENTER, CMD_ESC).
- Sub-module ps2_code_decode covers the decode FSM, timeout, key map and held flags. It outputs a one-cycle cmd strobe plus a cmd code.
- The top level keeps cursor, selection and the move handshake.

Test Plan:
- After rst, send E0 74 then E0 F0 74 -> cur_col 5->6 one cycle after the byte 74 is accepted. The break code changes nothing.
- Send 1D make 12 times with no break -> cur_row changes 5->4 once only. Then send F0 1D and 11 more single make/break pairs -> cur_row saturates at 0 and never wraps.
- At cursor (3,3): ENTER, RIGHT twice, ENTER, with move_ready held 0 for 20 cycles -> move_from={3,3}, move_to={3,5}, move_valid stays stable. Send LEFT during the wait -> dropped. Raise move_ready -> move_valid=0 and sel_valid=0 the next cycle.
- ENTER, then ESC -> cancel_pulse high exactly one cycle, sel_valid=0. ENTER twice on the same square -> selects then deselects, no move issued.
- Send E0, then wait TIMEOUT_CYC cycles -> err_pulse high one cycle and FSM back in IDLE. Then send 75 -> treated as an unknown non-extended code, no cursor change.
- Assert rst while move_valid=1 -> the next cycle all outputs equal the reset values (cursor at 5,5).
